sdram_arbiter: RTL and testbench

- Shares the single SDRAM controller command port between two requesters: port 0 (video scan-out, burst reads, deadline-critical) and port 1 (CPU/general bus, single or burst transfers).
- Fixed priority to port 0, with a bounded-starvation guard for port 1.
- Each transaction runs from command accept to requester ACK. Responses are routed back only to the granted requester.
- Sits between the video controller / CPU bus bridge and the SDRAM controller.

---
 rtl/sdram_arbiter.sv | 218 +++++++++++++++++++++
 tb/tb_sdram_arbiter.sv | 385 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sdram_arbiter.sv
// sdram_arbiter
//   Shares one SDRAM controller command port between two requesters.
//   Port 0 (video scan-out) has fixed priority. Port 1 (CPU bus) is
//   guaranteed one grant after VID_MAX_CONSEC back-to-back port-0 grants
//   taken while it was waiting. A transaction runs from command accept to
//   the owner's ACK. A watchdog force-releases an owner that goes silent
//   for ACK_TIMEOUT cycles.
//
// Ports
//   clk_i, rst_ni                 clock, async active-low reset
//   mN_cmd_valid / mN_cmd_ready   requester command handshake (ready = 1-cycle pulse)
//   mN_wr, mN_addr_x16, mN_wdata  requester command payload
//   mN_resp_valid, mN_rdata       read data routed back to the owner only
//   mN_ack                        requester ends its transaction
//   s_cmd_valid / s_cmd_ready     controller command handshake
//   s_wr, s_addr_x16, s_wdata     payload latched at accept, held until taken
//   s_resp_valid, s_rdata         controller read data
//   s_ack                         owner's ACK (or forced release), delayed 1 cycle
//   grant_o                       one-hot current owner, 00 = none
//   err_timeout_o                 sticky: a forced release has happened
module sdram_arbiter #(
  parameter int VID_MAX_CONSEC = 4,
  parameter int ACK_TIMEOUT    = 1024,
  parameter int AW             = 24
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic          m0_cmd_valid,
  output logic          m0_cmd_ready,
  input  logic          m0_wr,
  input  logic [AW-1:0] m0_addr_x16,
  input  logic [15:0]   m0_wdata,
  output logic          m0_resp_valid,
  output logic [15:0]   m0_rdata,
  input  logic          m0_ack,
  input  logic          m1_cmd_valid,
  output logic          m1_cmd_ready,
  input  logic          m1_wr,
  input  logic [AW-1:0] m1_addr_x16,
  input  logic [15:0]   m1_wdata,
  output logic          m1_resp_valid,
  output logic [15:0]   m1_rdata,
  input  logic          m1_ack,
  output logic          s_cmd_valid,
  input  logic          s_cmd_ready,
  output logic          s_wr,
  output logic [AW-1:0] s_addr_x16,
  output logic [15:0]   s_wdata,
  input  logic          s_resp_valid,
  input  logic [15:0]   s_rdata,
  output logic          s_ack,
  output logic [1:0]    grant_o,
  output logic          err_timeout_o
);

  localparam int CW = $clog2(VID_MAX_CONSEC + 1);
  localparam int TW = $clog2(ACK_TIMEOUT + 1);
  localparam logic [CW-1:0] CONSEC_MAX = CW'(VID_MAX_CONSEC);
  localparam logic [TW-1:0] TMO_LAST   = TW'(ACK_TIMEOUT - 1);

  typedef enum logic [1:0] {IDLE, ISSUE, BUSY} state_t;

  state_t        state_q, state_d;
  logic [1:0]    grant_q, grant_d;
  logic [CW-1:0] consec_q, consec_d;
  logic [TW-1:0] tmo_q, tmo_d;
  logic          err_q, err_d;
  logic          rdy0_q, rdy0_d, rdy1_q, rdy1_d;
  logic          rv0_q, rv0_d, rv1_q, rv1_d;
  logic [15:0]   rd0_q, rd0_d, rd1_q, rd1_d;
  logic          sack_q, sack_d;
  logic          swr_q, swr_d;
  logic [AW-1:0] saddr_q, saddr_d;
  logic [15:0]   swd_q, swd_d;

  logic pick1;
  logic own_ack;

  // Port 1 wins when port 0 is idle, or when video has used up its run.
  assign pick1   = m1_cmd_valid && (!m0_cmd_valid || (consec_q == CONSEC_MAX));
  // Only the current owner's ACK counts; the other port's ACK is ignored.
  assign own_ack = grant_q[1] ? m1_ack : m0_ack;

  always_comb begin
    state_d  = state_q;
    grant_d  = grant_q;
    consec_d = consec_q;
    tmo_d    = '0;
    err_d    = err_q;
    rdy0_d   = 1'b0;
    rdy1_d   = 1'b0;
    rv0_d    = 1'b0;
    rv1_d    = 1'b0;
    rd0_d    = rd0_q;
    rd1_d    = rd1_q;
    sack_d   = 1'b0;
    swr_d    = swr_q;
    saddr_d  = saddr_q;
    swd_d    = swd_q;

    unique case (state_q)
      IDLE: begin
        if (m0_cmd_valid || m1_cmd_valid) begin
          state_d = ISSUE;
          if (pick1) begin
            grant_d  = 2'b10;
            rdy1_d   = 1'b1;
            consec_d = '0;
            swr_d    = m1_wr;
            saddr_d  = m1_addr_x16;
            swd_d    = m1_wdata;
          end else begin
            grant_d = 2'b01;
            rdy0_d  = 1'b1;
            swr_d   = m0_wr;
            saddr_d = m0_addr_x16;
            swd_d   = m0_wdata;
            // The run length only grows while port 1 is actually waiting.
            if (!m1_cmd_valid) begin
              consec_d = '0;
            end else if (consec_q != CONSEC_MAX) begin
              consec_d = consec_q + 1'b1;
            end
          end
        end
      end

      ISSUE: begin
        if (s_cmd_ready) begin
          state_d = BUSY;
        end
      end

      BUSY: begin
        if (s_resp_valid) begin
          if (grant_q[1]) begin
            rv1_d = 1'b1;
            rd1_d = s_rdata;
          end else begin
            rv0_d = 1'b1;
            rd0_d = s_rdata;
          end
        end
        if (own_ack) begin
          sack_d  = 1'b1;
          state_d = IDLE;
          grant_d = 2'b00;
        end else if (s_resp_valid) begin
          tmo_d = '0;
        end else if (tmo_q == TMO_LAST) begin
          // Owner went silent: release the port and emit the ACK on its behalf.
          sack_d  = 1'b1;
          err_d   = 1'b1;
          state_d = IDLE;
          grant_d = 2'b00;
        end else begin
          tmo_d = tmo_q + 1'b1;
        end
      end

      default: begin
        state_d = IDLE;
        grant_d = 2'b00;
      end
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q  <= IDLE;
      grant_q  <= 2'b00;
      consec_q <= '0;
      tmo_q    <= '0;
      err_q    <= 1'b0;
      rdy0_q   <= 1'b0;
      rdy1_q   <= 1'b0;
      rv0_q    <= 1'b0;
      rv1_q    <= 1'b0;
      rd0_q    <= '0;
      rd1_q    <= '0;
      sack_q   <= 1'b0;
      swr_q    <= 1'b0;
      saddr_q  <= '0;
      swd_q    <= '0;
    end else begin
      state_q  <= state_d;
      grant_q  <= grant_d;
      consec_q <= consec_d;
      tmo_q    <= tmo_d;
      err_q    <= err_d;
      rdy0_q   <= rdy0_d;
      rdy1_q   <= rdy1_d;
      rv0_q    <= rv0_d;
      rv1_q    <= rv1_d;
      rd0_q    <= rd0_d;
      rd1_q    <= rd1_d;
      sack_q   <= sack_d;
      swr_q    <= swr_d;
      saddr_q  <= saddr_d;
      swd_q    <= swd_d;
    end
  end

  assign m0_cmd_ready  = rdy0_q;
  assign m1_cmd_ready  = rdy1_q;
  assign m0_resp_valid = rv0_q;
  assign m1_resp_valid = rv1_q;
  assign m0_rdata      = rd0_q;
  assign m1_rdata      = rd1_q;
  assign s_cmd_valid   = (state_q == ISSUE);
  assign s_wr          = swr_q;
  assign s_addr_x16    = saddr_q;
  assign s_wdata       = swd_q;
  assign s_ack         = sack_q;
  assign grant_o       = grant_q;
  assign err_timeout_o = err_q;

endmodule

// File: tb/tb_sdram_arbiter.sv
// Bench for sdram_arbiter: directed scenarios with literal expectations,
// then randomized requester/controller traffic. A transaction-level
// reference model predicts every output on every cycle.
module tb_sdram_arbiter;

  localparam int MAXC = 4;
  localparam int TMO  = 16;
  localparam int AW   = 24;

  logic          clk_i = 1'b0;
  logic          rst_ni;
  logic          m0_cmd_valid, m0_cmd_ready, m0_wr, m0_resp_valid, m0_ack;
  logic [AW-1:0] m0_addr_x16;
  logic [15:0]   m0_wdata, m0_rdata;
  logic          m1_cmd_valid, m1_cmd_ready, m1_wr, m1_resp_valid, m1_ack;
  logic [AW-1:0] m1_addr_x16;
  logic [15:0]   m1_wdata, m1_rdata;
  logic          s_cmd_valid, s_cmd_ready, s_wr, s_resp_valid, s_ack;
  logic [AW-1:0] s_addr_x16;
  logic [15:0]   s_wdata, s_rdata;
  logic [1:0]    grant_o;
  logic          err_timeout_o;

  sdram_arbiter #(.VID_MAX_CONSEC(MAXC), .ACK_TIMEOUT(TMO), .AW(AW)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni),
    .m0_cmd_valid(m0_cmd_valid), .m0_cmd_ready(m0_cmd_ready), .m0_wr(m0_wr),
    .m0_addr_x16(m0_addr_x16), .m0_wdata(m0_wdata), .m0_resp_valid(m0_resp_valid),
    .m0_rdata(m0_rdata), .m0_ack(m0_ack),
    .m1_cmd_valid(m1_cmd_valid), .m1_cmd_ready(m1_cmd_ready), .m1_wr(m1_wr),
    .m1_addr_x16(m1_addr_x16), .m1_wdata(m1_wdata), .m1_resp_valid(m1_resp_valid),
    .m1_rdata(m1_rdata), .m1_ack(m1_ack),
    .s_cmd_valid(s_cmd_valid), .s_cmd_ready(s_cmd_ready), .s_wr(s_wr),
    .s_addr_x16(s_addr_x16), .s_wdata(s_wdata), .s_resp_valid(s_resp_valid),
    .s_rdata(s_rdata), .s_ack(s_ack), .grant_o(grant_o), .err_timeout_o(err_timeout_o)
  );

  always #5 clk_i = ~clk_i;

  int total = 0;
  int bad   = 0;
  int cnt0  = 0;
  int cnt1  = 0;

  // Reference model: one open transaction record plus the video run length.
  bit            act_t    = 1'b0;
  int            port_t   = 0;
  bit            issued_t = 1'b0;
  int            quiet    = 0;
  int            run      = 0;
  logic          e_rdy0, e_rdy1, e_rv0, e_rv1, e_sack, e_err, e_wr;
  logic [15:0]   e_rd0, e_rd1, e_wd;
  logic [AW-1:0] e_addr;

  int exp_seq[10] = '{0, 0, 0, 0, 1, 0, 0, 0, 0, 1};
  int got_seq[10];

  // Random-traffic agent state
  bit            pend[2], intx[2], hang[2], pwr[2];
  int            need[2], got[2], dly[2];
  logic [AW-1:0] paddr[2];
  logic [15:0]   pwd[2];
  int            words;
  bit            sr_prev, scv_prev;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      if (bad <= 40) $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    act_t = 1'b0; port_t = 0; issued_t = 1'b0; quiet = 0; run = 0;
    e_rdy0 = 1'b0; e_rdy1 = 1'b0; e_rv0 = 1'b0; e_rv1 = 1'b0; e_sack = 1'b0;
    e_err = 1'b0; e_wr = 1'b0; e_rd0 = '0; e_rd1 = '0; e_wd = '0; e_addr = '0;
  endtask

  // Runs at the falling edge: compares outputs, then predicts the next
  // cycle from the inputs that the coming rising edge will sample.
  task automatic model_cycle();
    logic [1:0] eg;
    int w;
    if (m0_resp_valid === 1'b1) cnt0++;
    if (m1_resp_valid === 1'b1) cnt1++;
    if (rst_ni !== 1'b1) model_reset();
    eg = !act_t ? 2'b00 : ((port_t == 1) ? 2'b10 : 2'b01);
    chk("grant", 32'(grant_o), 32'(eg));
    chk("m0_cmd_ready", 32'(m0_cmd_ready), 32'(e_rdy0));
    chk("m1_cmd_ready", 32'(m1_cmd_ready), 32'(e_rdy1));
    chk("s_cmd_valid", 32'(s_cmd_valid), 32'(act_t && !issued_t));
    chk("s_wr", 32'(s_wr), 32'(e_wr));
    chk("s_addr", 32'(s_addr_x16), 32'(e_addr));
    chk("s_wdata", 32'(s_wdata), 32'(e_wd));
    chk("m0_resp_valid", 32'(m0_resp_valid), 32'(e_rv0));
    chk("m1_resp_valid", 32'(m1_resp_valid), 32'(e_rv1));
    chk("m0_rdata", 32'(m0_rdata), 32'(e_rd0));
    chk("m1_rdata", 32'(m1_rdata), 32'(e_rd1));
    chk("s_ack", 32'(s_ack), 32'(e_sack));
    chk("err_timeout", 32'(err_timeout_o), 32'(e_err));
    if (rst_ni === 1'b1) begin
      e_rdy0 = 1'b0; e_rdy1 = 1'b0; e_rv0 = 1'b0; e_rv1 = 1'b0; e_sack = 1'b0;
      if (!act_t) begin
        if (m0_cmd_valid || m1_cmd_valid) begin
          w = (m1_cmd_valid && (!m0_cmd_valid || run == MAXC)) ? 1 : 0;
          if (w == 0 && m1_cmd_valid) run = (run < MAXC) ? run + 1 : MAXC;
          else run = 0;
          if (w == 1) begin
            e_wr = m1_wr; e_addr = m1_addr_x16; e_wd = m1_wdata; e_rdy1 = 1'b1;
          end else begin
            e_wr = m0_wr; e_addr = m0_addr_x16; e_wd = m0_wdata; e_rdy0 = 1'b1;
          end
          act_t = 1'b1; port_t = w; issued_t = 1'b0; quiet = 0;
        end
      end else if (!issued_t) begin
        if (s_cmd_ready) issued_t = 1'b1;
      end else begin
        if (s_resp_valid) begin
          if (port_t == 1) begin e_rv1 = 1'b1; e_rd1 = s_rdata; end
          else begin e_rv0 = 1'b1; e_rd0 = s_rdata; end
        end
        if ((port_t == 1) ? m1_ack : m0_ack) begin
          e_sack = 1'b1; act_t = 1'b0;
        end else if (s_resp_valid) begin
          quiet = 0;
        end else if (quiet == TMO - 1) begin
          e_sack = 1'b1; e_err = 1'b1; act_t = 1'b0;
        end else begin
          quiet++;
        end
      end
    end
  endtask

  task automatic step();
    @(negedge clk_i);
    model_cycle();
    @(posedge clk_i);
    #1;
  endtask

  task automatic wait_rdy(input int p, output int n);
    n = 0;
    do begin
      step();
      n++;
    end while (!((p == 1) ? m1_cmd_ready : m0_cmd_ready) && n < 20);
    chk("cmd_ready_seen", 32'((p == 1) ? m1_cmd_ready : m0_cmd_ready), 32'd1);
  endtask

  task automatic wait_any(output int w);
    int n = 0;
    do begin
      step();
      n++;
    end while (!(m0_cmd_ready || m1_cmd_ready) && n < 20);
    chk("any_ready_seen", 32'(m0_cmd_ready || m1_cmd_ready), 32'd1);
    w = m1_cmd_ready ? 1 : 0;
  endtask

  task automatic handshake();
    s_cmd_ready = 1'b1;
    step();
    s_cmd_ready = 1'b0;
  endtask

  task automatic rnd_cycle();
    logic [1:0] rdy, rv, ak;
    int gp;
    rdy = {m1_cmd_ready, m0_cmd_ready};
    rv  = {m1_resp_valid, m0_resp_valid};
    ak  = 2'b00;
    for (int i = 0; i < 2; i++) begin
      if (rdy[i]) begin
        pend[i] = 1'b0; intx[i] = 1'b1; got[i] = 0;
      end else if (intx[i] && !grant_o[i]) begin
        intx[i] = 1'b0;
      end
      if (intx[i] && rv[i]) got[i]++;
      if (intx[i] && !hang[i] && got[i] >= need[i]) begin
        if (dly[i] == 0) begin ak[i] = 1'b1; intx[i] = 1'b0; end
        else dly[i]--;
      end else if (!intx[i] && $urandom_range(99) < 4) begin
        ak[i] = 1'b1;
      end
      if (!pend[i] && !intx[i] && $urandom_range(99) < 35) begin
        pend[i]  = 1'b1;
        pwr[i]   = 1'($urandom_range(1));
        paddr[i] = AW'($urandom);
        pwd[i]   = 16'($urandom);
        need[i]  = pwr[i] ? 1 : int'($urandom_range(8, 1));
        hang[i]  = ($urandom_range(99) < 4);
        dly[i]   = int'($urandom_range(3));
      end
    end
    m0_cmd_valid = pend[0]; m0_wr = pwr[0]; m0_addr_x16 = paddr[0]; m0_wdata = pwd[0]; m0_ack = ak[0];
    m1_cmd_valid = pend[1]; m1_wr = pwr[1]; m1_addr_x16 = paddr[1]; m1_wdata = pwd[1]; m1_ack = ak[1];
    if (sr_prev && scv_prev) begin
      gp = grant_o[1] ? 1 : 0;
      words = need[gp];
    end
    if (words > 0 && $urandom_range(99) < 60) begin
      s_resp_valid = 1'b1;
      words--;
    end else begin
      s_resp_valid = ($urandom_range(99) < 3);
    end
    s_rdata = 16'($urandom);
    s_cmd_ready = s_cmd_valid ? ($urandom_range(99) < 50) : ($urandom_range(99) < 10);
    sr_prev  = s_cmd_ready;
    scv_prev = s_cmd_valid;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int n, w, c0, c1;
    model_reset();
    rst_ni = 1'b0;
    m0_cmd_valid = 1'b0; m0_wr = 1'b0; m0_addr_x16 = '0; m0_wdata = '0; m0_ack = 1'b0;
    m1_cmd_valid = 1'b0; m1_wr = 1'b0; m1_addr_x16 = '0; m1_wdata = '0; m1_ack = 1'b0;
    s_cmd_ready = 1'b0; s_resp_valid = 1'b0; s_rdata = '0;
    step();
    step();
    chk("rst_grant", 32'(grant_o), 32'd0);
    chk("rst_err", 32'(err_timeout_o), 32'd0);
    chk("rst_scv", 32'(s_cmd_valid), 32'd0);
    rst_ni = 1'b1;
    step();

    // Port-0 burst read with a stalled controller, plus a stray port-1 ACK.
    m0_cmd_valid = 1'b1; m0_wr = 1'b0; m0_addr_x16 = 24'h800000;
    wait_rdy(0, n);
    chk("rd_ready_latency", 32'(n), 32'd1);
    chk("rd_grant", 32'(grant_o), 32'd1);
    m0_cmd_valid = 1'b0; m0_addr_x16 = '0;
    for (int k = 0; k < 3; k++) begin
      step();
      chk("rd_stall_scv", 32'(s_cmd_valid), 32'd1);
      chk("rd_stall_addr", 32'(s_addr_x16), 32'h800000);
    end
    handshake();
    chk("rd_scv_drop", 32'(s_cmd_valid), 32'd0);
    c0 = cnt0; c1 = cnt1;
    for (int k = 0; k < 64; k++) begin
      s_resp_valid = 1'b1;
      s_rdata = 16'(k * 3 + 1);
      m1_ack = (k == 10);
      step();
      chk("rd_word", 32'(m0_rdata), 32'(k * 3 + 1));
      chk("rd_no_sack", 32'(s_ack), 32'd0);
      chk("rd_hold_grant", 32'(grant_o), 32'd1);
    end
    s_resp_valid = 1'b0; m1_ack = 1'b0;
    step();
    chk("rd_words0", 32'(cnt0 - c0), 32'd64);
    chk("rd_words1", 32'(cnt1 - c1), 32'd0);
    m0_ack = 1'b1;
    step();
    m0_ack = 1'b0;
    chk("rd_sack", 32'(s_ack), 32'd1);
    chk("rd_release", 32'(grant_o), 32'd0);
    step();
    chk("rd_sack_pulse", 32'(s_ack), 32'd0);

    // Both ports requesting continuously.
    m0_cmd_valid = 1'b1; m1_cmd_valid = 1'b1; m1_addr_x16 = 24'h000042;
    for (int t = 0; t < 10; t++) begin
      wait_any(w);
      got_seq[t] = w;
      handshake();
      if (w == 1) m1_ack = 1'b1; else m0_ack = 1'b1;
      step();
      m0_ack = 1'b0; m1_ack = 1'b0;
    end
    m0_cmd_valid = 1'b0; m1_cmd_valid = 1'b0;
    for (int t = 0; t < 10; t++) chk("grant_seq", 32'(got_seq[t]), 32'(exp_seq[t]));
    step();

    // Port-1 single-word write with a stalled controller.
    m1_cmd_valid = 1'b1; m1_wr = 1'b1; m1_addr_x16 = 24'h000123; m1_wdata = 16'hBEEF;
    wait_rdy(1, n);
    chk("wr_ready_latency", 32'(n), 32'd1);
    chk("wr_grant", 32'(grant_o), 32'd2);
    m1_cmd_valid = 1'b0; m1_addr_x16 = 24'hFFFFFF; m1_wdata = 16'h0000; m1_wr = 1'b0;
    for (int k = 0; k < 3; k++) begin
      step();
      chk("wr_s_wr", 32'(s_wr), 32'd1);
      chk("wr_s_addr", 32'(s_addr_x16), 32'h000123);
      chk("wr_s_wdata", 32'(s_wdata), 32'hBEEF);
    end
    handshake();
    m1_ack = 1'b1;
    step();
    m1_ack = 1'b0;
    chk("wr_sack", 32'(s_ack), 32'd1);
    chk("wr_release", 32'(grant_o), 32'd0);
    step();

    // Port 0 goes silent; port 1 waits behind it.
    m0_cmd_valid = 1'b1; m0_wr = 1'b0; m0_addr_x16 = 24'h000400;
    wait_rdy(0, n);
    m0_cmd_valid = 1'b0;
    m1_cmd_valid = 1'b1; m1_wr = 1'b0; m1_addr_x16 = 24'h000055;
    handshake();
    n = 0;
    do begin
      step();
      n++;
    end while (s_ack !== 1'b1 && n < 40);
    chk("tmo_cycles", 32'(n), 32'd16);
    chk("tmo_err", 32'(err_timeout_o), 32'd1);
    chk("tmo_release", 32'(grant_o), 32'd0);
    wait_rdy(1, n);
    chk("tmo_next_latency", 32'(n), 32'd1);
    chk("tmo_next_grant", 32'(grant_o), 32'd2);
    m1_cmd_valid = 1'b0;
    handshake();
    for (int k = 0; k < 2; k++) begin
      s_resp_valid = 1'b1; s_rdata = 16'(16'hA000 + k);
      step();
    end
    s_resp_valid = 1'b0;
    chk("tmo_m1_word", 32'(m1_rdata), 32'hA001);
    m1_ack = 1'b1;
    step();
    m1_ack = 1'b0;
    step();
    chk("tmo_err_sticky", 32'(err_timeout_o), 32'd1);

    // Asynchronous reset in the middle of a burst.
    m0_cmd_valid = 1'b1; m0_addr_x16 = 24'h800000;
    wait_rdy(0, n);
    m0_cmd_valid = 1'b0;
    handshake();
    for (int k = 0; k < 20; k++) begin
      s_resp_valid = 1'b1; s_rdata = 16'(16'h5500 + k);
      step();
    end
    chk("rst_mid_word", 32'(m0_rdata), 32'h5513);
    #2;
    rst_ni = 1'b0;
    #1;
    chk("arst_grant", 32'(grant_o), 32'd0);
    chk("arst_resp", 32'(m0_resp_valid), 32'd0);
    chk("arst_rdata", 32'(m0_rdata), 32'd0);
    chk("arst_scv", 32'(s_cmd_valid), 32'd0);
    chk("arst_sack", 32'(s_ack), 32'd0);
    chk("arst_err", 32'(err_timeout_o), 32'd0);
    chk("arst_addr", 32'(s_addr_x16), 32'd0);
    s_resp_valid = 1'b0;
    step();
    rst_ni = 1'b1;
    m1_cmd_valid = 1'b1; m1_wr = 1'b0; m1_addr_x16 = 24'h000777;
    wait_rdy(1, n);
    chk("post_rst_latency", 32'(n), 32'd1);
    chk("post_rst_grant", 32'(grant_o), 32'd2);
    m1_cmd_valid = 1'b0;
    handshake();
    m1_ack = 1'b1;
    step();
    m1_ack = 1'b0;
    chk("post_rst_sack", 32'(s_ack), 32'd1);
    step();

    // Randomized traffic against the model.
    for (int i = 0; i < 2; i++) begin
      pend[i] = 1'b0; intx[i] = 1'b0; hang[i] = 1'b0; pwr[i] = 1'b0;
      need[i] = 0; got[i] = 0; dly[i] = 0; paddr[i] = '0; pwd[i] = '0;
    end
    words = 0; sr_prev = 1'b0; scv_prev = 1'b0;
    for (int c = 0; c < 4000; c++) begin
      rnd_cycle();
      step();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
